// File: rtl/fft_energy_pkg.sv
// Shared types and default widths for the FFT unload power accumulator.
package fft_energy_pkg;
  typedef enum logic {
    COLLECT = 1'b0,
    REPORT  = 1'b1
  } state_e;

  localparam int DATA_W_DEF      = 16;
  localparam int NFFT_LOG2_DEF   = 10;
  localparam int FRAMES_LOG2_DEF = 3;
  localparam int ACC_W_DEF       = 48;
  // carry bit above the accumulator used to detect saturation
  localparam int SAT_GUARD_W     = 1;
endpackage

// File: rtl/power_square_pipe.sv
// Two-stage |X|^2 pipeline: squares, then sum; dv/last/index travel alongside.
module power_square_pipe
  import fft_energy_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dv_i,
  input  logic                 last_i,
  input  logic [NFFT_LOG2-1:0] index_i,
  input  logic [DATA_W-1:0]    re_i,
  input  logic [DATA_W-1:0]    im_i,
  output logic                 dv_o,
  output logic                 last_o,
  output logic [NFFT_LOG2-1:0] index_o,
  output logic [2*DATA_W:0]    power_o
);
  logic signed [2*DATA_W-1:0] re_prod, im_prod;
  logic [2*DATA_W-1:0]        re_sq_q, im_sq_q;
  logic                       dv1_q, last1_q, dv2_q, last2_q;
  logic [NFFT_LOG2-1:0]       idx1_q, idx2_q;
  logic [2*DATA_W:0]          power_q;

  // a signed square is never negative, so the product reinterprets as unsigned
  assign re_prod = $signed(re_i) * $signed(re_i);
  assign im_prod = $signed(im_i) * $signed(im_i);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      dv1_q   <= 1'b0;
      last1_q <= 1'b0;
      idx1_q  <= '0;
      power_q <= '0;
      dv2_q   <= 1'b0;
      last2_q <= 1'b0;
      idx2_q  <= '0;
    end else begin
      re_sq_q <= $unsigned(re_prod);
      im_sq_q <= $unsigned(im_prod);
      dv1_q   <= dv_i;
      last1_q <= last_i;
      idx1_q  <= index_i;
      power_q <= {1'b0, re_sq_q} + {1'b0, im_sq_q};
      dv2_q   <= dv1_q;
      last2_q <= last1_q;
      idx2_q  <= idx1_q;
    end
  end

  assign dv_o    = dv2_q;
  assign last_o  = last2_q;
  assign index_o = idx2_q;
  assign power_o = power_q;
endmodule

// File: rtl/fft_unload_power_accumulator.sv
// Averages |X|^2 band energy over 2^FRAMES_LOG2 frames and reports it with a valid/ack handshake.
// Optional BIN_MASK_EN adds bin_lo/bin_hi to restrict which bins accumulate.
module fft_unload_power_accumulator
  import fft_energy_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NFFT_LOG2   = NFFT_LOG2_DEF,
  parameter int FRAMES_LOG2 = FRAMES_LOG2_DEF,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dv_fft_core,
  input  logic [DATA_W-1:0]    xk_re,
  input  logic [DATA_W-1:0]    xk_im,
  input  logic [NFFT_LOG2-1:0] xk_index,
  input  logic [ACC_W-1:0]     threshold,
  input  logic                 frame_ack,
`ifdef BIN_MASK_EN
  input  logic [NFFT_LOG2-1:0] bin_lo,
  input  logic [NFFT_LOG2-1:0] bin_hi,
`endif
  output logic [ACC_W-1:0]     energy_out,
  output logic                 energy_valid,
  output logic                 detect,
  output logic                 busy,
  output logic                 dropped_frame,
  output logic                 overflow
);
  localparam int SUM_W  = ACC_W + SAT_GUARD_W;
  localparam int PW_W   = 2*DATA_W + 1;
  localparam int FCNT_W = FRAMES_LOG2 + 1;
  localparam logic [NFFT_LOG2-1:0] LAST_IDX = '1;
  localparam logic [FCNT_W-1:0]    FRAME_TC = FCNT_W'((1 << FRAMES_LOG2) - 1);

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d, thr_q, thr_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic                 in_frame_q, in_frame_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;

  logic                 last_in, pipe_dv;
  logic [DATA_W-1:0]    re_m, im_m;
  logic                 dv2, last2;
  logic [NFFT_LOG2-1:0] idx2;
  logic [PW_W-1:0]      pw2;
  logic [SUM_W-1:0]     sum;
  logic                 accept;

  assign last_in = dv_fft_core && (xk_index == LAST_IDX);
  // samples arriving during REPORT never enter the pipe, so nothing stale survives the ack
  assign pipe_dv = dv_fft_core && (state_q == COLLECT);

`ifdef BIN_MASK_EN
  logic [NFFT_LOG2-1:0] lo_q, hi_q, lo_eff, hi_eff;
  logic                 frame_start, in_band;

  assign frame_start = dv_fft_core && (xk_index == '0);
  assign lo_eff      = frame_start ? bin_lo : lo_q;
  assign hi_eff      = frame_start ? bin_hi : hi_q;
  assign in_band     = (xk_index >= lo_eff) && (xk_index <= hi_eff);
  // out-of-band bins still flow through for frame tracking but contribute zero power
  assign re_m        = in_band ? xk_re : '0;
  assign im_m        = in_band ? xk_im : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (frame_start) begin
      lo_q <= bin_lo;
      hi_q <= bin_hi;
    end
  end
`else
  assign re_m = xk_re;
  assign im_m = xk_im;
`endif

  power_square_pipe #(
    .DATA_W   (DATA_W),
    .NFFT_LOG2(NFFT_LOG2)
  ) u_pipe (
    .clock  (clock),
    .reset  (reset),
    .dv_i   (pipe_dv),
    .last_i (last_in),
    .index_i(xk_index),
    .re_i   (re_m),
    .im_i   (im_m),
    .dv_o   (dv2),
    .last_o (last2),
    .index_o(idx2),
    .power_o(pw2)
  );

  assign sum    = SUM_W'(acc_q) + SUM_W'(pw2);
  assign accept = (state_q == COLLECT) && dv2 && (in_frame_q || (idx2 == '0));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    thr_d      = thr_q;
    fcnt_d     = fcnt_q;
    in_frame_d = in_frame_q;
    ovf_d      = ovf_q;
    drop_d     = (state_q == REPORT) && last_in;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          in_frame_d = !last2;
          if (last2) begin
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == FRAME_TC) begin
              state_d = REPORT;
              thr_d   = threshold;
            end
          end
        end
      end
      REPORT: begin
        if (frame_ack) begin
          acc_d      = '0;
          fcnt_d     = '0;
          ovf_d      = 1'b0;
          in_frame_d = 1'b0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      acc_q      <= '0;
      thr_q      <= '0;
      fcnt_q     <= '0;
      in_frame_q <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      thr_q      <= thr_d;
      fcnt_q     <= fcnt_d;
      in_frame_q <= in_frame_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign energy_valid  = (state_q == REPORT);
  assign busy          = energy_valid;
  assign energy_out    = energy_valid ? (acc_q >> FRAMES_LOG2) : '0;
  assign detect        = energy_valid && (energy_out > thr_q);
  assign dropped_frame = drop_q;
  assign overflow      = ovf_q;
endmodule

// File: doc/fft_unload_power_accumulator.md
Name: fft_unload_power_accumulator

Overview:
Receive-side counterpart of the FFT controller's unload phase. It consumes the bin stream the FFT core emits after unload (dv, xk_re, xk_im, xk_index) and computes |X|^2 per bin. It accumulates band energy over 2^FRAMES_LOG2 frames, then presents the averaged energy and a threshold decision to the detection logic with a valid/ack handshake.

Parameters:
DATA_W, 16, signed width of xk_re/xk_im
NFFT_LOG2, 10, log2 of FFT length; bins per frame = 2^NFFT_LOG2
FRAMES_LOG2, 3, log2 of frames averaged per report
ACC_W, 48, accumulator and energy_out width; must be >= 2*DATA_W+1

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
dv_fft_core  in  1  FFT output data valid
xk_re  in  DATA_W  signed real part of bin
xk_im  in  DATA_W  signed imaginary part of bin
xk_index  in  NFFT_LOG2  bin index of current sample
threshold  in  ACC_W  unsigned detection threshold, sampled when entering REPORT
frame_ack  in  1  consumer accepts the current report
energy_out  out  ACC_W  averaged energy: accumulated sum >> FRAMES_LOG2
energy_valid  out  1  report held valid until frame_ack
detect  out  1  energy_out > threshold; qualified by energy_valid
busy  out  1  high in REPORT; frames arriving now are dropped
dropped_frame  out  1  one-cycle pulse per frame discarded during REPORT
overflow  out  1  sticky; accumulator saturated during this report window

Behaviour:
- Reset values: all outputs 0; accumulator 0; frame counter 0; state COLLECT.
- Power pipe: stage 1 registers re*re and im*im (2*DATA_W unsigned each); stage 2 registers their sum (2*DATA_W+1 bits). Each stage carries dv and a last flag. last = dv_fft_core && xk_index == 2^NFFT_LOG2-1.
- Accumulate: in COLLECT, each valid stage-2 result is added to acc. If the sum exceeds 2^ACC_W-1, acc saturates at all-ones and overflow sets.
- Frame end: taken only from last, not from dv falling. dv gaps inside a frame are tolerated. On the accumulate of a last sample, frame_cnt increments.
- States:
  - COLLECT: accumulate. When the last sample of frame 2^FRAMES_LOG2-1 accumulates, go to REPORT.
  - REPORT: energy_out = acc >> FRAMES_LOG2. detect = energy_out > threshold. energy_valid=1, busy=1. Incoming samples are ignored. dropped_frame pulses one cycle after each last sample seen at the input. On frame_ack: clear acc, frame_cnt, overflow and energy_valid; return to COLLECT on the next cycle.
- Latency: energy_valid rises 3 cycles after the input cycle carrying the final last sample (2 pipe stages + accumulate/transition).
- Frame already in flight when frame_ack arrives: samples already inside the pipe when REPORT exits are discarded. The next accepted frame starts at the first input sample after the return to COLLECT. Frames only count once index 0 has been seen, so a partial frame is skipped until the next index 0.
- frame_ack when energy_valid=0: ignored.
- Reset mid-operation: asynchronously clears the pipe, acc and flags immediately; no partial report is produced.

Optional Feature:
BIN_MASK_EN.
- Defined: adds ports bin_lo, bin_hi (NFFT_LOG2 each, in), sampled at the start of each frame. Only samples with bin_lo <= xk_index <= bin_hi are accumulated. Masked samples still advance frame tracking.
- Undefined: all bins accumulate and the ports do not exist.

Decomposition:
- Shared package fft_energy_pkg: state enum (COLLECT, REPORT), the DATA_W/NFFT_LOG2/ACC_W defaults, and a saturating-add width constant.
- One sub-module, power_square_pipe: the 2-stage |X|^2 pipeline carrying dv/last/index alongside the data.
- Control, accumulation and handshake stay in the top module.

Test Plan:
Bench configuration: NFFT_LOG2=3, FRAMES_LOG2=1, ACC_W=48 unless noted.
- Basic report: 2 frames of 8 bins, re=100, im=0, threshold=50000. Required: energy_valid rises 3 cycles after the last sample; energy_out=80000; detect=1; overflow=0.
- Hold and clear: keep frame_ack low 20 cycles, then pulse it. Required: energy_out is stable while held; after the ack, energy_valid=0, and the next 2 frames of re=3, im=4 give energy_out=200.
- Dropped frame: send one full frame while in REPORT. Required: exactly one dropped_frame pulse; energy_out unchanged; a post-ack report does not include that frame.
- Saturation: ACC_W=34, re=im=-32768, 2 frames. Required: energy_out=(2^34-1)>>1; overflow=1 until ack.
- dv gaps and reset: 3-cycle dv gaps mid-frame give the same result as the basic report. Asserting reset mid-frame clears all outputs and acc asynchronously; the next 2 full frames give the normal result.
